mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles without mem_ack before forced completion (legal range 2..65535).
REQ-002 clk  in  1  single clock; all flops rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 if_req  in  1  fetch-stage request; held until if_ready.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata  out  32  fetch read data; valid when if_ready=1.
REQ-007 if_ready  out  1  fetch transaction complete this cycle.
REQ-008 dm_req, dm_we  in  1 each  memory-stage request, write enable; req held until dm_ready.
REQ-009 dm_addr, dm_wdata  in  32 each  data address, store data.
REQ-010 dm_be  in  4  store byte enables.
REQ-011 dm_rdata  out  32; dm_ready  out  1  load data, completion strobe.
REQ-012 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_be  out  4  shared single-port memory request.
REQ-013 mem_rdata  in  32; mem_ack  in  1  memory read data, completion.
REQ-014 stall_f, stall_m  out  1 each  pipeline stall for fetch / memory stage.
REQ-015 err  out  1  timeout strobe, one cycle.

Function
REQ-016 FSM states IDLE, BUSY_IF, BUSY_DM; one memory transaction outstanding at most.
REQ-017 IDLE: dm_req=1 -> BUSY_DM; else if_req=1 -> BUSY_IF; else stay; grant cycle latches addr/we/wdata/be into registers.
REQ-018 BUSY_x: mem_req=1 and mem_* driven from latched registers only; mem_we=0, mem_be=0 in BUSY_IF.
REQ-019 IDLE: mem_req=0, mem_we=0.
REQ-020 x_ready = (state==BUSY_x) && mem_ack, combinational; x_rdata = mem_rdata in that cycle, else 0; next state IDLE.
REQ-021 Minimum latency: req in cycle N, ready earliest in cycle N+1 (zero-wait memory).
REQ-022 stall_f = if_req && !if_ready; stall_m = dm_req && !dm_ready.
REQ-023 Timeout counter clears on grant, increments each BUSY cycle without mem_ack; at count TIMEOUT_CYCLES-1 without ack: x_ready=1, x_rdata=0, err=1, next IDLE.
REQ-024 mem_ack in IDLE ignored; no ready, no error.
REQ-025 Requester dropping req mid-transaction (flush): transaction still completes on memory; ready strobe still issued.
REQ-026 Counter width = $clog2(TIMEOUT_CYCLES+1); no wrap possible.

Reset
REQ-027 rst=0 asynchronously forces IDLE, counter 0, latched registers 0, all outputs 0, including mid-transaction; first grant possible in first cycle after release.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: last-grant flop; simultaneous if_req and dm_req in IDLE grant opposite of last grant (reset value: last=IF, so DM first).
REQ-029 Macro undefined: fixed priority, dm_req always wins; no last-grant flop.

Structure
REQ-030 Package core_pkg holds arb_state_t enum and TIMEOUT_CYCLES_DEFAULT constant.
REQ-031 One sub-module, mem_timeout_counter (clear, enable, expired output).

Verification
REQ-032 Single load, ack 1 cycle after grant, mem_rdata=32'hDEADBEEF -> dm_ready=1, dm_rdata=32'hDEADBEEF, stall_m low next cycle.
REQ-033 if_req and dm_req same cycle, macro undefined -> BUSY_DM first, then BUSY_IF; with MEM_ARB_RR_EN, back-to-back -> DM, IF, DM, IF.
REQ-034 Store dm_addr=32'h100, dm_be=4'b0011, 3 wait cycles -> mem_we=1, mem_be=4'b0011 stable for 4 cycles, dm_ready on ack.
REQ-035 TIMEOUT_CYCLES=4, no ack -> err=1 and if_ready=1 with if_rdata=0 in 4th BUSY cycle; late ack ignored.
REQ-036 rst=0 asserted in BUSY_DM -> mem_req=0 immediately, IDLE after release, no ready strobe.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the arbiter state encoding and the default timeout length.
// No logic, so there is no latency and no backpressure here.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without an ack and flags when the limit is reached.
// The expired flag is combinational from the count register.
// The count saturates at LIMIT-1, so it can never wrap.
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory (MEM_ARB_RR_EN: round-robin).
// Latency: grant in the request cycle, ready earliest one cycle later; timeout forces completion.
// Backpressure: one transaction at a time, and the losing requester stalls until its ready strobe.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m,
  output logic        err
);

  arb_state_t  state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic        grant_if, grant_dm, pick_dm, expired, busy;

`ifdef MEM_ARB_RR_EN
  // Reset to "last was IF" so the first tie goes to the data side.
  logic last_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_if <= 1'b1;
    end else if (grant_if || grant_dm) begin
      last_if <= grant_if;
    end
  end

  assign pick_dm = dm_req && (!if_req || last_if);
`else
  assign pick_dm = dm_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else if (grant_dm) begin
      addr_q  <= dm_addr;
      wdata_q <= dm_wdata;
      we_q    <= dm_we;
      be_q    <= dm_be;
    end else if (grant_if) begin
      addr_q  <= if_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end
  end

  assign busy = (state != ST_IDLE);

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_if || grant_dm),
    .enable  (busy && !mem_ack),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    dm_ready  = 1'b0;
    dm_rdata  = '0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      ST_IDLE: begin
        if (pick_dm) begin
          grant_dm  = 1'b1;
          state_nxt = ST_BUSY_DM;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          if_ready  = 1'b1;
          if_rdata  = mem_rdata;
          state_nxt = ST_IDLE;
        end else if (expired) begin
          if_ready  = 1'b1;
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_DM: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (mem_ack) begin
          dm_ready  = 1'b1;
          dm_rdata  = mem_rdata;
          state_nxt = ST_IDLE;
        end else if (expired) begin
          dm_ready  = 1'b1;
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated by reset so every output reads 0 while rst is low.
  assign stall_f = rst && if_req && !if_ready;
  assign stall_m = rst && dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f, stall_m, err;

  int ack_wait  = 0;
  bit force_ack = 1'b0;
  int busy_cnt  = 0;
  int checks    = 0;
  int errors    = 0;

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .err       (err)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endfunction

  function automatic void push(bit dm, logic [31:0] rdata, bit e, logic [31:0] addr);
    exp_t x;
    x.dm = dm; x.rdata = rdata; x.err = e; x.addr = addr;
    q.push_back(x);
  endfunction

  // Memory model: acks after ack_wait BUSY cycles (never if negative).
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        mem_ack = force_ack || (ack_wait >= 0 && busy_cnt == ack_wait);
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        mem_ack  = force_ack;
      end
    end
  end

  // Monitor: every ready strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: if_ready=%b dm_ready=%b with nothing expected", if_ready, dm_ready);
        end else begin
          e = q.pop_front();
          chk("ready_channel_dm", 32'(dm_ready), 32'(e.dm));
          chk("ready_channel_if", 32'(if_ready), 32'(!e.dm));
          chk("rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
          chk("other_rdata_zero", e.dm ? if_rdata : dm_rdata, 32'd0);
          chk("err", 32'(err), 32'(e.err));
          chk("mem_addr_at_done", mem_addr, e.addr);
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready: err=1 with no ready strobe");
      end
    end
  end

  // Holds a request until its ready strobe; called just after a rising edge.
  task automatic txn(input bit dm, input logic [31:0] addr, input bit we,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input int exp_lat, input bit bus_chk, input string nm);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    if (dm) begin
      dm_req = 1'b1; dm_addr = addr; dm_we = we; dm_wdata = wdata; dm_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus_chk && mem_req) begin
        chk({nm, "_mem_we"}, 32'(mem_we), dm ? 32'(we) : 32'd0);
        chk({nm, "_mem_be"}, 32'(mem_be), dm ? 32'(be) : 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, addr);
      end
      if (dm ? dm_ready : if_ready) begin
        done = 1'b1;
        chk({nm, "_stall_at_ready"}, dm ? 32'(stall_m) : 32'(stall_f), 32'd0);
      end else begin
        chk({nm, "_stall_waiting"}, dm ? 32'(stall_m) : 32'(stall_f), 32'd1);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_no_ready: no ready after %0d cycles, expected within 40", nm, n);
    end
    chk({nm, "_latency"}, n - 1, exp_lat);
    @(posedge clk);
    #1;
    if (dm) dm_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    mem_rdata = 32'h0;

    // Reset state with requests asserted.
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_stall_m", 32'(stall_m), 32'd0);
    chk("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;

    // Single load, zero-wait memory.
    ack_wait = 0; mem_rdata = 32'hDEADBEEF;
    push(1'b1, 32'hDEADBEEF, 1'b0, 32'h40);
    txn(1'b1, 32'h40, 1'b0, 32'h0, 4'hF, 1, 1'b1, "load");
    @(negedge clk);
    chk("load_stall_m_after", 32'(stall_m), 32'd0);
    chk("load_no_second_ready", 32'(dm_ready), 32'd0);

    // Fetch read with one wait cycle.
    @(posedge clk); #1;
    ack_wait = 1; mem_rdata = 32'hCAFE0001;
    push(1'b0, 32'hCAFE0001, 1'b0, 32'h1000);
    txn(1'b0, 32'h1000, 1'b0, 32'h0, 4'h0, 2, 1'b1, "fetch");

    // Store with three wait cycles; ack lands on the timeout boundary cycle.
    ack_wait = 3; mem_rdata = 32'h12345678;
    push(1'b1, 32'h12345678, 1'b0, 32'h100);
    txn(1'b1, 32'h100, 1'b1, 32'hA5A5A5A5, 4'b0011, 4, 1'b1, "store");

    // Fetch timeout, then late acks in IDLE must be ignored.
    ack_wait = -1; mem_rdata = 32'hFFFFFFFF;
    push(1'b0, 32'h0, 1'b1, 32'h2000);
    txn(1'b0, 32'h2000, 1'b0, 32'h0, 4'h0, 4, 1'b1, "timeout");
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_err", 32'(err), 32'd0);
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;

    // Simultaneous requests from reset-equivalent history: data side first.
    ack_wait = 0; mem_rdata = 32'h0BADF00D;
    push(1'b1, 32'h0BADF00D, 1'b0, 32'h300);
    push(1'b0, 32'h0BADF00D, 1'b0, 32'h3000);
    fork
      txn(1'b1, 32'h300, 1'b0, 32'h0, 4'hF, 1, 1'b0, "pair1_dm");
      txn(1'b0, 32'h3000, 1'b0, 32'h0, 4'h0, 3, 1'b0, "pair1_if");
    join

    // Data alone, then a tie: round-robin serves fetch first, fixed priority serves data.
    mem_rdata = 32'h00C0FFEE;
    push(1'b1, 32'h00C0FFEE, 1'b0, 32'h400);
    txn(1'b1, 32'h400, 1'b0, 32'h0, 4'hF, 1, 1'b1, "solo_dm");
`ifdef MEM_ARB_RR_EN
    push(1'b0, 32'h00C0FFEE, 1'b0, 32'h4000);
    push(1'b1, 32'h00C0FFEE, 1'b0, 32'h500);
    fork
      txn(1'b1, 32'h500, 1'b0, 32'h0, 4'hF, 3, 1'b0, "pair2_dm");
      txn(1'b0, 32'h4000, 1'b0, 32'h0, 4'h0, 1, 1'b0, "pair2_if");
    join
`else
    push(1'b1, 32'h00C0FFEE, 1'b0, 32'h500);
    push(1'b0, 32'h00C0FFEE, 1'b0, 32'h4000);
    fork
      txn(1'b1, 32'h500, 1'b0, 32'h0, 4'hF, 1, 1'b0, "pair2_dm");
      txn(1'b0, 32'h4000, 1'b0, 32'h0, 4'h0, 3, 1'b0, "pair2_if");
    join
`endif

    // Flush: request dropped after grant, completion still strobes.
    ack_wait = 2; mem_rdata = 32'h600D600D;
    push(1'b1, 32'h600D600D, 1'b0, 32'h200);
    dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_be = 4'hF;
    @(posedge clk); #1;
    dm_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 20);
    chk("flush_ready_seen", 32'(dm_ready), 32'd1);
    chk("flush_latency", n, 3);
    chk("flush_stall_m", 32'(stall_m), 32'd0);

    // Reset in the middle of a store.
    @(posedge clk); #1;
    ack_wait = -1;
    dm_req = 1'b1; dm_addr = 32'h300; dm_we = 1'b1; dm_wdata = 32'h77; dm_be = 4'hC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_mem_req_now", 32'(mem_req), 32'd0);
    chk("midrst_mem_we_now", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr_now", mem_addr, 32'd0);
    @(negedge clk);
    chk("midrst_dm_ready", 32'(dm_ready), 32'd0);
    chk("midrst_stall_m", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; dm_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_idle_mem_req", 32'(mem_req), 32'd0);
    end

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
